// File: rtl/dcache_write_buffer.sv
// Circular write buffer between the dcache write port and the AXI bridge write channel,
// with line-address read-after-write hazard blocking. Define WBUF_MERGE_EN to merge word stores into the tail.
module dcache_write_buffer #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         s_wr_req,
  input  logic [2:0]   s_wr_type,
  input  logic [31:0]  s_wr_addr,
  input  logic [3:0]   s_wr_wstrb,
  input  logic [127:0] s_wr_data,
  output logic         s_wr_rdy,
  input  logic         s_rd_req,
  input  logic [31:0]  s_rd_addr,
  output logic         s_rd_rdy,
  output logic         m_wr_req,
  output logic [2:0]   m_wr_type,
  output logic [31:0]  m_wr_addr,
  output logic [3:0]   m_wr_wstrb,
  output logic [127:0] m_wr_data,
  input  logic         m_wr_rdy,
  output logic         m_rd_req,
  input  logic         m_rd_rdy,
  output logic         wbuf_empty
);

  logic [2:0]   type_q  [DEPTH];
  logic [31:0]  addr_q  [DEPTH];
  logic [3:0]   wstrb_q [DEPTH];
  logic [127:0] data_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic accept, push, pop, merge, hazard;
  logic [PTR_W-1:0] tail_idx, off;
  logic unused_rd_lsb;

  assign unused_rd_lsb = ^s_rd_addr[3:0];
  assign tail_idx      = wr_ptr_q - PTR_W'(1);

  assign s_wr_rdy   = (count_q != (PTR_W+1)'(DEPTH));
  assign wbuf_empty = (count_q == '0);
  assign m_wr_req   = !wbuf_empty;
  assign accept     = s_wr_req && s_wr_rdy;
  assign pop        = m_wr_req && m_wr_rdy;

`ifdef WBUF_MERGE_EN
  // Tail must not be the head: merging into an entry already on the bus would change it mid-handshake.
  assign merge = accept && (s_wr_type == 3'b010) && (type_q[tail_idx] == 3'b010) &&
                 (addr_q[tail_idx] == s_wr_addr) && (count_q >= (PTR_W+1)'(2));
`else
  assign merge = 1'b0;
`endif
  assign push = accept && !merge;

  // Head fields read as zero when empty, so the storage array needs no reset.
  assign m_wr_type  = m_wr_req ? type_q[rd_ptr_q]  : '0;
  assign m_wr_addr  = m_wr_req ? addr_q[rd_ptr_q]  : '0;
  assign m_wr_wstrb = m_wr_req ? wstrb_q[rd_ptr_q] : '0;
  assign m_wr_data  = m_wr_req ? data_q[rd_ptr_q]  : '0;

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    hazard = accept && (s_wr_addr[31:4] == s_rd_addr[31:4]);
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (addr_q[i][31:4] == s_rd_addr[31:4])) hazard = 1'b1;
    end
  end

  assign m_rd_req = s_rd_req && !hazard;
  assign s_rd_rdy = m_rd_rdy && !hazard;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d = rd_ptr_q + (pop  ? PTR_W'(1) : PTR_W'(0));
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the entry array is deliberately not reset; validity comes from count and the output mux.
  always_ff @(posedge clock) begin
    if (push) begin
      type_q[wr_ptr_q]  <= s_wr_type;
      addr_q[wr_ptr_q]  <= s_wr_addr;
      wstrb_q[wr_ptr_q] <= s_wr_wstrb;
      data_q[wr_ptr_q]  <= s_wr_data;
    end
`ifdef WBUF_MERGE_EN
    else if (merge) begin
      for (int b = 0; b < 4; b++) begin
        if (s_wr_wstrb[b]) begin
          data_q[tail_idx][8*b +: 8] <= s_wr_data[8*b +: 8];
          wstrb_q[tail_idx][b]       <= 1'b1;
        end
      end
    end
`endif
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer: scoreboard of expected writes popped as the bridge side drains.
module tb_dcache_write_buffer;

  typedef struct packed {
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wr_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         s_wr_req = 1'b0;
  logic [2:0]   s_wr_type = '0;
  logic [31:0]  s_wr_addr = '0;
  logic [3:0]   s_wr_wstrb = '0;
  logic [127:0] s_wr_data = '0;
  logic         s_wr_rdy;
  logic         s_rd_req = 1'b0;
  logic [31:0]  s_rd_addr = '0;
  logic         s_rd_rdy;
  logic         m_wr_req;
  logic [2:0]   m_wr_type;
  logic [31:0]  m_wr_addr;
  logic [3:0]   m_wr_wstrb;
  logic [127:0] m_wr_data;
  logic         m_wr_rdy = 1'b0;
  logic         m_rd_req;
  logic         m_rd_rdy = 1'b0;
  logic         wbuf_empty;

  int  n_vec  = 0;
  int  n_err  = 0;
  int  n_pops = 0;
  wr_t sb[$];

  always #5 clock = ~clock;

  dcache_write_buffer #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .s_wr_req(s_wr_req), .s_wr_type(s_wr_type), .s_wr_addr(s_wr_addr),
    .s_wr_wstrb(s_wr_wstrb), .s_wr_data(s_wr_data), .s_wr_rdy(s_wr_rdy),
    .s_rd_req(s_rd_req), .s_rd_addr(s_rd_addr), .s_rd_rdy(s_rd_rdy),
    .m_wr_req(m_wr_req), .m_wr_type(m_wr_type), .m_wr_addr(m_wr_addr),
    .m_wr_wstrb(m_wr_wstrb), .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy),
    .m_rd_req(m_rd_req), .m_rd_rdy(m_rd_rdy), .wbuf_empty(wbuf_empty)
  );

  // Bridge-side monitor: each handshake must present the oldest expected write.
  always @(negedge clock) begin
    if (!reset && m_wr_req && m_wr_rdy) begin
      wr_t exp_w;
      wr_t got_w;
      n_vec++;
      n_pops++;
      got_w = {m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data};
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got addr=%h type=%b, expected no write", m_wr_addr, m_wr_type);
      end else begin
        exp_w = sb.pop_front();
        if (got_w !== exp_w)
          begin
            n_err++;
            $display("FAIL pop_fields: got type=%b addr=%h strb=%b data=%h, expected type=%b addr=%h strb=%b data=%h",
                     got_w.typ, got_w.addr, got_w.wstrb, got_w.data,
                     exp_w.typ, exp_w.addr, exp_w.wstrb, exp_w.data);
          end
      end
    end
  end

  function automatic wr_t mk(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                             input logic [127:0] d);
    wr_t w;
    w.typ = t; w.addr = a; w.wstrb = s; w.data = d;
    return w;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input wr_t w, input bit merge_exp, input wr_t merged);
    bit done;
    done       = 1'b0;
    s_wr_type  = w.typ;
    s_wr_addr  = w.addr;
    s_wr_wstrb = w.wstrb;
    s_wr_data  = w.data;
    s_wr_req   = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (s_wr_rdy) begin
        if (merge_exp) sb[sb.size()-1] = merged;
        else           sb.push_back(w);
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    s_wr_req = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout: got s_wr_rdy=%b for 50 cycles, expected 1", s_wr_rdy);
    end
  endtask

  task automatic wait_empty(output bit ok);
    ok = 1'b0;
    m_wr_rdy = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (wbuf_empty) ok = 1'b1;
    end
    m_wr_rdy = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_vec++;
    if ({m_wr_req, s_wr_rdy, wbuf_empty, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data} !== {3'b011, 167'd0}) begin
      n_err++;
      $display("FAIL reset_state: got req=%b rdy=%b empty=%b addr=%h data=%h, expected 0 1 1 0 0",
               m_wr_req, s_wr_rdy, wbuf_empty, m_wr_addr, m_wr_data);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single_line;
    wr_t w;
    w = mk(3'b100, 32'h0000_1230, 4'b1111, {4{32'hA5A5_A5A5}});
    m_wr_rdy = 1'b1;
    push(w, 1'b0, w);
    @(negedge clock);
    n_vec++;
    if ({m_wr_req, wbuf_empty} !== 2'b10) begin
      n_err++;
      $display("FAIL single_req: got req=%b empty=%b, expected 1 0", m_wr_req, wbuf_empty);
    end
    @(negedge clock);
    n_vec++;
    if ({m_wr_req, wbuf_empty, m_wr_data} !== {2'b01, 128'd0}) begin
      n_err++;
      $display("FAIL single_drained: got req=%b empty=%b data=%h, expected 0 1 0", m_wr_req, wbuf_empty, m_wr_data);
    end
    m_wr_rdy = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_full_wrap;
    wr_t w[5];
    bit  ok;
    w[0] = mk(3'b000, 32'h0000_0101, 4'b0010, 128'h0000_AA00);
    w[1] = mk(3'b001, 32'h0000_0202, 4'b1100, 128'hBEEF_0000);
    w[2] = mk(3'b010, 32'h0000_0304, 4'b1111, {$urandom, $urandom, $urandom, $urandom});
    w[3] = mk(3'b100, 32'h0000_0400, 4'b1111, {$urandom, $urandom, $urandom, $urandom});
    w[4] = mk(3'b111, 32'h0000_0508, 4'b0101, {$urandom, $urandom, $urandom, $urandom});
    m_wr_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(w[i], 1'b0, w[i]);
    n_vec++;
    if (s_wr_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL full_rdy: got s_wr_rdy=%b after 4 pushes, expected 0", s_wr_rdy);
    end
    s_wr_type = w[4].typ; s_wr_addr = w[4].addr; s_wr_wstrb = w[4].wstrb; s_wr_data = w[4].data;
    s_wr_req  = 1'b1;
    @(negedge clock);
    n_vec++;
    if (s_wr_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL full_hold: got s_wr_rdy=%b while full, expected 0", s_wr_rdy);
    end
    @(posedge clock);
    #1;
    m_wr_rdy = 1'b1;
    @(posedge clock);
    #1;
    m_wr_rdy = 1'b0;
    @(negedge clock);
    n_vec++;
    if (s_wr_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL full_after_pop: got s_wr_rdy=%b, expected 1", s_wr_rdy);
    end
    sb.push_back(w[4]);
    @(posedge clock);
    #1;
    s_wr_req = 1'b0;
    @(negedge clock);
    n_vec++;
    if ({s_wr_rdy, m_wr_addr} !== {1'b0, w[1].addr}) begin
      n_err++;
      $display("FAIL full_wrap: got rdy=%b head=%h, expected 0 %h", s_wr_rdy, m_wr_addr, w[1].addr);
    end
    @(posedge clock);
    #1;
    wait_empty(ok);
    n_vec++;
    if (!ok || sb.size() != 0) begin
      n_err++;
      $display("FAIL full_drain: got empty=%b left=%0d, expected 1 0", ok, sb.size());
    end
  endtask

  task automatic test_hazard;
    wr_t w;
    wr_t w2;
    bit  ok;
    w  = mk(3'b100, 32'h0000_2040, 4'b1111, {$urandom, $urandom, $urandom, $urandom});
    w2 = mk(3'b100, 32'h0000_3008, 4'b1111, {$urandom, $urandom, $urandom, $urandom});
    m_wr_rdy = 1'b0;
    push(w, 1'b0, w);
    s_rd_req = 1'b1; s_rd_addr = 32'h0000_204C; m_rd_rdy = 1'b1;
    #1;
    n_vec++;
    if ({m_rd_req, s_rd_rdy} !== 2'b00) begin
      n_err++;
      $display("FAIL hazard_block: got m_rd_req=%b s_rd_rdy=%b, expected 0 0", m_rd_req, s_rd_rdy);
    end
    s_rd_addr = 32'h0000_2050;
    #1;
    n_vec++;
    if ({m_rd_req, s_rd_rdy} !== 2'b11) begin
      n_err++;
      $display("FAIL hazard_other_line: got m_rd_req=%b s_rd_rdy=%b, expected 1 1", m_rd_req, s_rd_rdy);
    end
    s_rd_addr = 32'h0000_204C;
    m_wr_rdy  = 1'b1;
    @(negedge clock);
    n_vec++;
    if (m_rd_req !== 1'b0) begin
      n_err++;
      $display("FAIL hazard_until_pop: got m_rd_req=%b, expected 0", m_rd_req);
    end
    @(posedge clock);
    #1;
    m_wr_rdy = 1'b0;
    n_vec++;
    if ({m_rd_req, s_rd_rdy} !== 2'b11) begin
      n_err++;
      $display("FAIL hazard_release: got m_rd_req=%b s_rd_rdy=%b, expected 1 1", m_rd_req, s_rd_rdy);
    end
    m_rd_rdy = 1'b0;
    #1;
    n_vec++;
    if ({m_rd_req, s_rd_rdy} !== 2'b10) begin
      n_err++;
      $display("FAIL rd_rdy_gate: got m_rd_req=%b s_rd_rdy=%b, expected 1 0", m_rd_req, s_rd_rdy);
    end
    m_rd_rdy  = 1'b1;
    s_rd_addr = 32'h0000_3000;
    s_wr_type = w2.typ; s_wr_addr = w2.addr; s_wr_wstrb = w2.wstrb; s_wr_data = w2.data;
    s_wr_req  = 1'b1;
    #1;
    n_vec++;
    if ({m_rd_req, s_rd_rdy} !== 2'b00) begin
      n_err++;
      $display("FAIL hazard_incoming: got m_rd_req=%b s_rd_rdy=%b, expected 0 0", m_rd_req, s_rd_rdy);
    end
    @(negedge clock);
    sb.push_back(w2);
    @(posedge clock);
    #1;
    s_wr_req = 1'b0;
    #1;
    n_vec++;
    if (m_rd_req !== 1'b0) begin
      n_err++;
      $display("FAIL hazard_buffered: got m_rd_req=%b, expected 0", m_rd_req);
    end
    s_rd_req = 1'b0;
    m_rd_rdy = 1'b0;
    wait_empty(ok);
    n_vec++;
    if (!ok || sb.size() != 0) begin
      n_err++;
      $display("FAIL hazard_drain: got empty=%b left=%0d, expected 1 0", ok, sb.size());
    end
  endtask

  task automatic test_push_pop_same_cycle;
    wr_t w[5];
    bit  ok;
    int  pops0;
    for (int i = 0; i < 5; i++)
      w[i] = mk(3'b010, 32'h0000_6000 + 32'(i * 16), 4'b1111, {96'd0, $urandom});
    m_wr_rdy = 1'b0;
    push(w[0], 1'b0, w[0]);
    push(w[1], 1'b0, w[1]);
    pops0 = n_pops;
    m_wr_rdy = 1'b1;
    push(w[2], 1'b0, w[2]);
    m_wr_rdy = 1'b0;
    n_vec++;
    if ({m_wr_addr, wbuf_empty, s_wr_rdy} !== {w[1].addr, 2'b01}) begin
      n_err++;
      $display("FAIL pushpop_head: got head=%h empty=%b rdy=%b, expected %h 0 1",
               m_wr_addr, wbuf_empty, s_wr_rdy, w[1].addr);
    end
    push(w[3], 1'b0, w[3]);
    push(w[4], 1'b0, w[4]);
    n_vec++;
    if (s_wr_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL pushpop_count: got s_wr_rdy=%b after refill to 4, expected 0", s_wr_rdy);
    end
    wait_empty(ok);
    n_vec++;
    if (!ok || sb.size() != 0 || (n_pops - pops0) != 5) begin
      n_err++;
      $display("FAIL pushpop_drain: got empty=%b left=%0d pops=%0d, expected 1 0 5",
               ok, sb.size(), n_pops - pops0);
    end
  endtask

  task automatic test_reset_mid_drain;
    wr_t w;
    bit  ok;
    m_wr_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = mk(3'b100, 32'h0000_7000 + 32'(i * 16), 4'b1111, {$urandom, $urandom, $urandom, $urandom});
      push(w, 1'b0, w);
    end
    m_wr_rdy = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({m_wr_req, wbuf_empty, s_wr_rdy, m_wr_addr, m_wr_data} !== {3'b011, 160'd0}) begin
      n_err++;
      $display("FAIL reset_async: got req=%b empty=%b rdy=%b addr=%h, expected 0 1 1 0",
               m_wr_req, wbuf_empty, s_wr_rdy, m_wr_addr);
    end
    sb.delete();
    m_wr_rdy = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    w = mk(3'b001, 32'h0000_8002, 4'b0011, 128'h0000_C0DE);
    push(w, 1'b0, w);
    n_vec++;
    if ({m_wr_req, m_wr_addr} !== {1'b1, w.addr}) begin
      n_err++;
      $display("FAIL reset_next_push: got req=%b head=%h, expected 1 %h", m_wr_req, m_wr_addr, w.addr);
    end
    wait_empty(ok);
    n_vec++;
    if (!ok || sb.size() != 0) begin
      n_err++;
      $display("FAIL reset_drain: got empty=%b left=%0d, expected 1 0", ok, sb.size());
    end
  endtask

`ifdef WBUF_MERGE_EN
  task automatic test_merge;
    wr_t h, t, m, mrg, x;
    bit  ok;
    int  pops0;
    h   = mk(3'b010, 32'h0000_0200, 4'b1111, 128'h5555_6666);
    t   = mk(3'b010, 32'h0000_0100, 4'b0011, 128'h1122_3344);
    m   = mk(3'b010, 32'h0000_0100, 4'b1100, 128'hAABB_CCDD);
    mrg = mk(3'b010, 32'h0000_0100, 4'b1111, 128'hAABB_3344);
    x   = mk(3'b010, 32'h0000_0300, 4'b1111, 128'h7777_8888);
    m_wr_rdy = 1'b0;
    pops0 = n_pops;
    push(h, 1'b0, h);
    push(t, 1'b0, t);
    push(m, 1'b1, mrg);
    push(x, 1'b0, x);
    n_vec++;
    if (s_wr_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL merge_count: got s_wr_rdy=%b with 3 entries, expected 1", s_wr_rdy);
    end
    wait_empty(ok);
    n_vec++;
    if (!ok || sb.size() != 0 || (n_pops - pops0) != 3) begin
      n_err++;
      $display("FAIL merge_drain: got empty=%b left=%0d pops=%0d, expected 1 0 3",
               ok, sb.size(), n_pops - pops0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_line();
    test_full_wrap();
    test_hazard();
    test_push_pop_same_cycle();
    test_reset_mid_drain();
`ifdef WBUF_MERGE_EN
    test_merge();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
